// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM/IO responder for the load/store buffer and instruction fetch
module mem_ctrl #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11,
    parameter int         ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic                  lsb_req,
    input  logic                  lsb_we,
    input  logic [2:0]            lsb_op,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_wdata,
    output logic                  lsb_done,
    output logic [31:0]           lsb_rdata,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              k, k1, n, req_op, req_n;
    logic [1:0]              cap;
    logic [ADDR_WIDTH-1:0]   base, req_addr;
    logic [31:0]             wdata, rbuf, rfull, rext;
    logic                    is_if, zext, io, wr_q, accept, stall, rd_last, wr_last;

    // A write byte is only presented to the bus while running and not blocked by a full IO buffer
    assign mem_wr = wr_q && rdy_in && !stall;

    // Request selection, byte-count decode and FSM next state
    always_comb begin
        accept    = (lsb_req || if_req) && !clear;
        req_addr  = lsb_req ? lsb_addr : if_addr;
        req_op    = lsb_req ? lsb_op : 3'b010;
        req_n     = (req_op[1:0] == 2'b00) ? 3'd1 : (req_op[1:0] == 2'b01) ? 3'd2 : 3'd4;
        k1        = k + 3'd1;
        stall     = io && io_buffer_full;
        rd_last   = (state == READ) && (k == n);
        wr_last   = (state == WRITE) && !stall && (k1 == n);
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? ((lsb_req && lsb_we) ? WRITE : READ) : IDLE;
            READ:    state_nxt = (clear || rd_last) ? IDLE : READ;
            WRITE:   state_nxt = wr_last ? IDLE : WRITE;
            default: state_nxt = IDLE;
        endcase
    end

    // Merge the byte arriving this cycle (offset k-1) and extend to 32 bits
    always_comb begin
        cap   = k[1:0] - 2'd1;
        rfull = rbuf;
        rfull[{cap, 3'b000} +: 8] = mem_din;
        rext  = (n == 3'd1) ? {{24{!zext && rfull[7]}}, rfull[7:0]} :
                (n == 3'd2) ? {{16{!zext && rfull[15]}}, rfull[15:0]} : rfull;
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!rst_in)
            state <= IDLE;
        else if (rdy_in)
            state <= state_nxt;
    end

    // Transaction datapath: latch request, step addresses, capture bytes, raise done
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            k         <= '0;
            n         <= '0;
            base      <= '0;
            wdata     <= '0;
            rbuf      <= '0;
            is_if     <= 1'b0;
            zext      <= 1'b0;
            io        <= 1'b0;
            wr_q      <= 1'b0;
            lsb_done  <= 1'b0;
            if_done   <= 1'b0;
            lsb_rdata <= '0;
            if_data   <= '0;
            mem_dout  <= '0;
            mem_a     <= '0;
        end else if (rdy_in) begin
            lsb_done <= 1'b0;
            if_done  <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    base     <= req_addr;
                    mem_a    <= req_addr;
                    k        <= '0;
                    n        <= req_n;
                    zext     <= req_op[2];
                    is_if    <= !lsb_req;
                    wdata    <= lsb_wdata;
                    io       <= req_addr[17:16] == IO_ADDR_HI;
                    wr_q     <= lsb_req && lsb_we;
                    mem_dout <= lsb_wdata[7:0];
                end
                READ: if (!clear) begin
                    k <= k1;
                    if (k1 < n)
                        mem_a <= base + ADDR_WIDTH'(k1);
                    if (k != 3'd0)
                        rbuf <= rfull;
                    if (rd_last && is_if) begin
                        if_done <= 1'b1;
                        if_data <= rext;
                    end
                    if (rd_last && !is_if) begin
                        lsb_done  <= 1'b1;
                        lsb_rdata <= rext;
                    end
                end
                WRITE: if (!stall) begin
                    if (wr_last) begin
                        wr_q      <= 1'b0;
                        lsb_done  <= 1'b1;
                        lsb_rdata <= '0;
                    end else begin
                        k        <= k1;
                        mem_a    <= base + ADDR_WIDTH'(k1);
                        mem_dout <= wdata[{k1[1:0], 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a byte RAM model
module tb_mem_ctrl;
    logic        clk_in = 0, rst_in = 0, rdy_in = 1, clear = 0;
    logic        lsb_req = 0, lsb_we = 0, if_req = 0, io_buffer_full = 0;
    logic [2:0]  lsb_op = 0;
    logic [31:0] lsb_addr = 0, lsb_wdata = 0, if_addr = 0;
    logic        lsb_done, if_done, mem_wr;
    logic [31:0] lsb_rdata, if_data, mem_a;
    logic [7:0]  mem_din = 0, mem_dout;

    typedef struct {bit is_if; logic [31:0] data; int cyc;} done_t;
    typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;

    done_t dq[$];
    wr_t   wq[$];
    done_t e;
    wr_t   w;
    int    cyc = 0, n_chk = 0, n_fail = 0, c;
    logic [7:0] ram [logic [31:0]];

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_op(lsb_op), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc++;

    // RAM: read byte for last cycle's address, writes committed at the edge
    always @(posedge clk_in) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    function void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function void exp_done(bit is_if, logic [31:0] data, int at);
        done_t d;
        d.is_if = is_if;
        d.data  = data;
        d.cyc   = at;
        dq.push_back(d);
    endfunction

    function void exp_wr(logic [31:0] a, logic [7:0] d);
        wr_t x;
        x.a = a;
        x.d = d;
        wq.push_back(x);
    endfunction

    // Monitor: pops expected responses whenever the DUT signals done or writes a byte
    always @(negedge clk_in) begin
        if (lsb_done || if_done) begin
            chk("done_exclusive", 32'(lsb_done && if_done), 32'd0);
            if (dq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: actual lsb_done=%0b if_done=%0b required none (cycle %0d)", lsb_done, if_done, cyc);
            end else begin
                e = dq.pop_front();
                chk("done_owner", 32'(if_done), 32'(e.is_if));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("done_data", if_done ? if_data : lsb_rdata, e.data);
            end
        end
        if (mem_wr) begin
            if (wq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: actual addr %h data %h required no write (cycle %0d)", mem_a, mem_dout, cyc);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", mem_a, w.a);
                chk("wr_data", 32'(mem_dout), 32'(w.d));
            end
        end
    end

    task automatic issue(input bit fetch, input bit we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
        bit got = 0;
        if (fetch) begin
            if_req = 1; if_addr = addr;
        end else begin
            lsb_req = 1; lsb_we = we; lsb_op = op; lsb_addr = addr; lsb_wdata = wd;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_in);
            got = fetch ? if_done : lsb_done;
        end
        if (fetch) if_req = 0; else lsb_req = 0;
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: actual no done required done for addr %h", addr);
        end
        @(posedge clk_in); #1;
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk_in);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h84;
        ram[32'h200] = 8'h80;
        step(3);
        chk("rst_lsb_done", 32'(lsb_done), 0);
        chk("rst_if_done", 32'(if_done), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_mem_a", mem_a, 0);
        rst_in = 1;
        step(1);

        c = cyc; exp_done(0, 32'h84332211, c + 6);
        issue(0, 0, 3'b010, 32'h100, 0);

        c = cyc; exp_done(0, 32'h84332211, c + 8);
        fork
            issue(0, 0, 3'b010, 32'h100, 0);
            begin step(5); rdy_in = 0; step(2); rdy_in = 1; end
        join

        c = cyc; exp_done(0, 32'hFFFFFF80, c + 3);
        issue(0, 0, 3'b000, 32'h200, 0);
        c = cyc; exp_done(0, 32'h00000080, c + 4);
        fork
            issue(0, 0, 3'b100, 32'h200, 0);
            begin clear = 1; step(1); clear = 0; end
        join

        c = cyc; exp_wr(32'h300, 8'hCD); exp_wr(32'h301, 8'hAB); exp_done(0, 0, c + 3);
        fork
            issue(0, 1, 3'b001, 32'h300, 32'h0000ABCD);
            begin step(1); clear = 1; step(2); clear = 0; end
        join

        c = cyc; exp_wr(32'h30000, 8'h41); exp_done(0, 0, c + 5);
        fork
            issue(0, 1, 3'b000, 32'h30000, 32'h41);
            begin io_buffer_full = 1; step(4); io_buffer_full = 0; end
        join

        c = cyc; exp_done(0, 32'hFFFFFF80, c + 3); exp_done(1, 32'h84332211, c + 9);
        fork
            issue(0, 0, 3'b000, 32'h200, 0);
            issue(1, 0, 3'b000, 32'h100, 0);
        join

        if_req = 1; if_addr = 32'h100;
        step(2);
        clear = 1;
        step(1);
        clear = 0; if_req = 0;
        step(3);
        chk("clear_mem_a_hold", mem_a, 32'h101);
        c = cyc; exp_done(0, 32'h00000080, c + 3);
        issue(0, 0, 3'b100, 32'h200, 0);

        exp_wr(32'h400, 8'h44); exp_wr(32'h401, 8'h33); exp_wr(32'h402, 8'h22);
        lsb_req = 1; lsb_we = 1; lsb_op = 3'b010; lsb_addr = 32'h400; lsb_wdata = 32'h11223344;
        step(3);
        rst_in = 0;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("rst2_mem_wr", 32'(mem_wr), 0);
        chk("rst2_mem_a", mem_a, 0);
        chk("rst2_mem_dout", 32'(mem_dout), 0);
        chk("rst2_lsb_rdata", lsb_rdata, 0);
        chk("rst2_if_data", if_data, 0);
        chk("rst2_done", 32'({lsb_done, if_done}), 0);
        step(1);
        lsb_req = 0; rst_in = 1;
        step(6);
        chk("pending_done", 32'(dq.size()), 0);
        chk("pending_writes", 32'(wq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
